ctrl_core_ext: RTL
==================

// Module: ctrl_core_ext
// PURPOSE
// Next-generation Sat Engine controller. Sequences BCP, decision, conflict analysis and
// current-bin backtrack for one loaded bin. Adds over the first generation:
// - one-cycle start pulses to every sub-unit
// - conflict-limit abort and per-phase watchdog timeout
// - external abort input
// - saturating statistics counters and an encoded completion status
// PARAMETERS
// WIDTH_BIN_ID  10  width of bin numbers
// WIDTH_LVL     16  width of decision level / cur_bin_num_i
// WIDTH_CNT     16  width of statistics counters
// MAX_CONFLICTS 0   conflicts per run before giving up; 0 = unlimited
// TIMEOUT_CYC   0   max cycles spent in one phase; 0 = watchdog disabled
// PORTS
// clk                 in   1             clock
// rst                 in   1             asynchronous active-low reset
// start_core_i        in   1             start a run; accepted only in IDLE
// abort_i             in   1             abandon the current run
// done_core_o         out  1             run finished; level signal
// apply_imply_o       out  1             start-BCP pulse
// done_imply_i        in   1             BCP done
// conflict_i          in   1             BCP hit a conflict; qualified by done_imply_i
// start_decision_o    out  1             start-decision pulse
// done_decision_i     in   1             decision done
// cur_lvl_i           in   WIDTH_LVL     current decision level (passed to max_lvl_o)
// all_c_is_sat_i      in   1             all clauses satisfied; qualified by done_decision_i
// apply_analyze_o     out  1             start-analysis pulse
// done_analyze_i      in   1             analysis done
// bkt_bin_num_i       in   WIDTH_BIN_ID  bin that analysis backtracks to
// apply_bkt_cur_bin_o out  1             start-backtrack pulse
// done_bkt_cur_bin_i  in   1             backtrack done
// cur_bin_num_i       in   WIDTH_LVL     bin being solved; compare zero-extends the narrower operand
// sat_o               out  1             run ended SAT
// unsat_o             out  1             run ended non-SAT (any cause)
// status_o            out  3             0 none, 1 sat, 2 bkt-other-bin, 3 conflict limit, 4 timeout, 5 abort
// conflict_cnt_o      out  WIDTH_CNT     conflicts this run; saturates
// decision_cnt_o      out  WIDTH_CNT     decisions this run; saturates
// max_lvl_o           out  WIDTH_LVL     highest cur_lvl_i seen at done_decision_i
// BEHAVIOUR
// - Reset (async, rst=0): state IDLE; all outputs 0. Reset mid-run discards the run;
//   sub-unit pulses drop immediately.
// - States: IDLE, BCP, DECISION, ANALYSIS, BKT, DONE. All outputs registered.
// - IDLE -> BCP on start_core_i.
//   - The same edge clears sat_o, unsat_o, done_core_o, status_o, counters and max_lvl_o.
//   - start_core_i outside IDLE is ignored.
// - Start pulses: on every entry into BCP/DECISION/ANALYSIS/BKT, the matching apply_*/start_*
//   output is 1 for exactly the first cycle in that state. Re-entry issues a new pulse.
// - Done inputs are sampled every cycle in the owning state, including the pulse cycle.
//   Done inputs from other states are ignored.
// - BCP on done_imply_i:
//   - conflict_i=0 -> DECISION.
//   - conflict_i=1 -> conflict_cnt++. Then go DONE, status 3, if MAX_CONFLICTS!=0 and the
//     new count == MAX_CONFLICTS. Otherwise -> ANALYSIS.
// - DECISION on done_decision_i:
//   - decision_cnt++; max_lvl_o updated.
//   - all_c_is_sat_i=1 -> DONE, status 1, sat_o=1.
//   - Otherwise -> BCP.
// - ANALYSIS on done_analyze_i:
//   - bkt_bin_num_i==cur_bin_num_i -> BKT.
//   - Otherwise -> DONE, status 2.
// - BKT on done_bkt_cur_bin_i -> DECISION.
// - Watchdog: a phase counter clears on each state entry.
//   - If TIMEOUT_CYC!=0 and TIMEOUT_CYC cycles pass in one phase without its done -> DONE, status 4.
//   - A done arriving in cycle TIMEOUT_CYC wins.
// - abort_i=1 in any state except IDLE/DONE -> DONE, status 5. Priority order:
//   abort > done/transition > timeout.
// - DONE: one cycle, then -> IDLE.
//   - Entry edge sets done_core_o=1, and unsat_o=1 for status 2..5.
//   - sat_o, unsat_o, done_core_o, status_o, counters and max_lvl_o hold until the next
//     accepted start.
// - Counters stop at all-ones. They never wrap.
// TESTING
// 1. start; BCP done no conflict; decision done with all_c_is_sat=1 -> sat_o=1, status 1,
//    decision_cnt=1, done_core_o high 1 cycle after DONE entry, each pulse exactly 1 cycle wide.
// 2. MAX_CONFLICTS=3, every BCP conflicts, bkt_bin==cur_bin -> 2 ANALYSIS/BKT loops, third
//    conflict -> status 3, unsat_o=1, conflict_cnt=3.
// 3. Conflict with bkt_bin_num_i=5, cur_bin_num_i=4 -> DONE, status 2; no apply_bkt_cur_bin_o pulse.
// 4. TIMEOUT_CYC=8, withhold done_decision_i -> status 4 after 8 DECISION cycles; same run with
//    done at cycle 8 -> proceeds to BCP.
// 5. abort_i in the same cycle as done_analyze_i -> status 5; start_core_i while in BCP -> no effect.
// 6. rst low mid-ANALYSIS -> all outputs 0 asynchronously; a new start after release runs a
//    clean SAT run with counters from 0.

Source files
------------

// File: rtl/ctrl_core_ext.sv
// rtl/ctrl_core_ext.sv - Sat Engine run sequencer: BCP/decision/analysis/backtrack with limits, watchdog and stats
module ctrl_core_ext #(
    parameter int WIDTH_BIN_ID  = 10,
    parameter int WIDTH_LVL     = 16,
    parameter int WIDTH_CNT     = 16,
    parameter int MAX_CONFLICTS = 0,
    parameter int TIMEOUT_CYC   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_core_i,
    input  logic                    abort_i,
    output logic                    done_core_o,
    output logic                    apply_imply_o,
    input  logic                    done_imply_i,
    input  logic                    conflict_i,
    output logic                    start_decision_o,
    input  logic                    done_decision_i,
    input  logic [WIDTH_LVL-1:0]    cur_lvl_i,
    input  logic                    all_c_is_sat_i,
    output logic                    apply_analyze_o,
    input  logic                    done_analyze_i,
    input  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i,
    output logic                    apply_bkt_cur_bin_o,
    input  logic                    done_bkt_cur_bin_i,
    input  logic [WIDTH_LVL-1:0]    cur_bin_num_i,
    output logic                    sat_o,
    output logic                    unsat_o,
    output logic [2:0]              status_o,
    output logic [WIDTH_CNT-1:0]    conflict_cnt_o,
    output logic [WIDTH_CNT-1:0]    decision_cnt_o,
    output logic [WIDTH_LVL-1:0]    max_lvl_o
);
    localparam int WIDTH_CMP = (WIDTH_BIN_ID > WIDTH_LVL) ? WIDTH_BIN_ID : WIDTH_LVL;

    localparam logic [2:0] ST_NONE      = 3'd0;
    localparam logic [2:0] ST_SAT       = 3'd1;
    localparam logic [2:0] ST_BKT_OTHER = 3'd2;
    localparam logic [2:0] ST_CONF_LIM  = 3'd3;
    localparam logic [2:0] ST_TIMEOUT   = 3'd4;
    localparam logic [2:0] ST_ABORT     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_BCP, S_DECISION, S_ANALYSIS, S_BKT, S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [2:0]           status_nxt;
    logic [31:0]          phase_cnt;
    logic [WIDTH_CNT-1:0] conflict_inc, decision_inc;
    logic                 phase_active, conflict_at_limit, timed_out, bin_match;
    logic                 entering, accepted_start;

    assign conflict_inc = (conflict_cnt_o == '1) ? conflict_cnt_o : conflict_cnt_o + WIDTH_CNT'(1);
    assign decision_inc = (decision_cnt_o == '1) ? decision_cnt_o : decision_cnt_o + WIDTH_CNT'(1);
    assign conflict_at_limit = (MAX_CONFLICTS != 0) && (32'(conflict_inc) == 32'(MAX_CONFLICTS));
    assign timed_out = (TIMEOUT_CYC != 0) && (phase_cnt == 32'(TIMEOUT_CYC - 1));
    assign bin_match = (WIDTH_CMP'(bkt_bin_num_i) == WIDTH_CMP'(cur_bin_num_i));
    assign phase_active = (state == S_BCP) || (state == S_DECISION) ||
                          (state == S_ANALYSIS) || (state == S_BKT);
    assign entering = (state_nxt != state);
    assign accepted_start = (state == S_IDLE) && start_core_i;

    always_comb begin
        state_nxt  = state;
        status_nxt = ST_NONE;
        case (state)
            S_IDLE: if (start_core_i) state_nxt = S_BCP;
            S_BCP: if (done_imply_i) begin
                if (!conflict_i) state_nxt = S_DECISION;
                else if (conflict_at_limit) begin
                    state_nxt  = S_DONE;
                    status_nxt = ST_CONF_LIM;
                end else state_nxt = S_ANALYSIS;
            end
            S_DECISION: if (done_decision_i) begin
                if (all_c_is_sat_i) begin
                    state_nxt  = S_DONE;
                    status_nxt = ST_SAT;
                end else state_nxt = S_BCP;
            end
            S_ANALYSIS: if (done_analyze_i) begin
                if (bin_match) state_nxt = S_BKT;
                else begin
                    state_nxt  = S_DONE;
                    status_nxt = ST_BKT_OTHER;
                end
            end
            S_BKT: if (done_bkt_cur_bin_i) state_nxt = S_DECISION;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // A done in the last allowed cycle already moved state_nxt, so it beats the watchdog.
        if (phase_active && timed_out && (state_nxt == state)) begin
            state_nxt  = S_DONE;
            status_nxt = ST_TIMEOUT;
        end
        if (phase_active && abort_i) begin
            state_nxt  = S_DONE;
            status_nxt = ST_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= S_IDLE;
            phase_cnt           <= '0;
            done_core_o         <= 1'b0;
            apply_imply_o       <= 1'b0;
            start_decision_o    <= 1'b0;
            apply_analyze_o     <= 1'b0;
            apply_bkt_cur_bin_o <= 1'b0;
            sat_o               <= 1'b0;
            unsat_o             <= 1'b0;
            status_o            <= ST_NONE;
            conflict_cnt_o      <= '0;
            decision_cnt_o      <= '0;
            max_lvl_o           <= '0;
        end else begin
            state               <= state_nxt;
            phase_cnt           <= entering ? '0 : phase_cnt + 32'd1;
            apply_imply_o       <= entering && (state_nxt == S_BCP);
            start_decision_o    <= entering && (state_nxt == S_DECISION);
            apply_analyze_o     <= entering && (state_nxt == S_ANALYSIS);
            apply_bkt_cur_bin_o <= entering && (state_nxt == S_BKT);
            if (accepted_start) begin
                done_core_o    <= 1'b0;
                sat_o          <= 1'b0;
                unsat_o        <= 1'b0;
                status_o       <= ST_NONE;
                conflict_cnt_o <= '0;
                decision_cnt_o <= '0;
                max_lvl_o      <= '0;
            end
            // Abort preempts the done it coincides with, statistics included.
            if (state == S_BCP && done_imply_i && conflict_i && !abort_i)
                conflict_cnt_o <= conflict_inc;
            if (state == S_DECISION && done_decision_i && !abort_i) begin
                decision_cnt_o <= decision_inc;
                if (cur_lvl_i > max_lvl_o) max_lvl_o <= cur_lvl_i;
            end
            if (entering && state_nxt == S_DONE) begin
                done_core_o <= 1'b1;
                status_o    <= status_nxt;
                sat_o       <= (status_nxt == ST_SAT);
                unsat_o     <= (status_nxt != ST_SAT);
            end
        end
    end
endmodule
